// File: rtl/icache_fetch_resp_pkg.sv
// icache_fetch_resp_pkg: shared fetch-line constants and the
// responder FSM state encoding.
package icache_fetch_resp_pkg;

  localparam int FETCH_LINE_BYTES = 16;
  localparam int FETCH_OFF_BITS   = $clog2(FETCH_LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/icache_fetch_reqq.sv
// icache_fetch_reqq: in-order circular queue of pending fetch requests.
// Ports: clk/rst, i_flush clears; i_push with {addr,id}; i_pop drops
// the head; o_count/o_full/o_empty status; o_head_addr/o_head_id.
module icache_fetch_reqq
  import icache_fetch_resp_pkg::*;
#(
  parameter  int PC_WIDTH = 32,
  parameter  int DEPTH    = 4,
  localparam int TAW      = PC_WIDTH - FETCH_OFF_BITS,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic           i_push,
  input  logic [TAW-1:0] i_push_addr,
  input  logic [1:0]     i_push_id,
  input  logic           i_pop,
  output logic [CW-1:0]  o_count,
  output logic           o_full,
  output logic           o_empty,
  output logic [TAW-1:0] o_head_addr,
  output logic [1:0]     o_head_id
);

  logic [TAW-1:0] r_addr [DEPTH];
  logic [1:0]     r_id   [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic w_push;
  logic w_pop;

  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_id   = r_id[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage needs no reset: validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_id[r_wr_ptr]   <= i_push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= nxt(r_rd_ptr);
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/icache_fetch_resp.sv
// icache_fetch_resp: IFU fetch responder. Queues tagged line requests,
// issues one memory read at a time, returns lines with their id.
// Ports: clk/rst; i_flush; IFU request (i_ifu_icache_*), stall and
// response (o_icache_ifu_*); memory read port (o_icache_mem_*,
// i_mem_icache_*).
module icache_fetch_resp
  import icache_fetch_resp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_ifu_icache_vld,
  input  logic [PC_WIDTH-1:0]   i_ifu_icache_pc_addr,
  input  logic [1:0]            i_ifu_icache_id,
  output logic                  o_icache_ifu_stall,
  output logic                  o_icache_ifu_vld,
  output logic [1:0]            o_icache_ifu_id,
  output logic [LINE_WIDTH-1:0] o_icache_ifu_data,
  output logic                  o_icache_mem_req,
  output logic [PC_WIDTH-1:0]   o_icache_mem_addr,
  input  logic                  i_mem_icache_gnt,
  input  logic                  i_mem_icache_rvld,
  input  logic [LINE_WIDTH-1:0] i_mem_icache_rdata
);

  localparam int TAW = PC_WIDTH - FETCH_OFF_BITS;
  localparam int CW  = $clog2(DEPTH) + 1;

  fetch_state_e          r_state;
  logic                  r_mem_req;
  logic [PC_WIDTH-1:0]   r_mem_addr;
  logic                  r_vld;
  logic [1:0]            r_id;
  logic [LINE_WIDTH-1:0] r_data;

  logic                  w_accept;
  logic                  w_pop;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [TAW-1:0]        w_head_addr;
  logic [1:0]            w_head_id;

  assign o_icache_ifu_stall = w_full | (r_state == ST_DRAIN);

  assign w_accept = i_ifu_icache_vld & ~o_icache_ifu_stall & ~i_flush;
  assign w_pop    = (r_state == ST_WAIT) & i_mem_icache_rvld
                  & ~i_flush & ~w_empty;

  icache_fetch_reqq #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_reqq (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_flush),
    .i_push      (w_accept),
    .i_push_addr (i_ifu_icache_pc_addr[PC_WIDTH-1:FETCH_OFF_BITS]),
    .i_push_id   (i_ifu_icache_id),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_id   (w_head_id)
  );

  // The head cannot change while in REQ (pops only happen in WAIT),
  // so the address is captured once on entry to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_vld      <= 1'b0;
      r_id       <= '0;
      r_data     <= '0;
    end else begin
      r_vld <= 1'b0;
      if (i_flush) begin
        // A granted read is still owed data; DRAIN absorbs it.
        r_mem_req <= 1'b0;
        unique case (r_state)
          ST_REQ:
            r_state <= i_mem_icache_gnt ? ST_DRAIN : ST_IDLE;
          ST_WAIT:
            r_state <= i_mem_icache_rvld ? ST_IDLE : ST_DRAIN;
          ST_DRAIN:
            r_state <= ST_DRAIN;
          default:
            r_state <= ST_IDLE;
        endcase
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_count != '0) begin
              r_state    <= ST_REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {w_head_addr, {FETCH_OFF_BITS{1'b0}}};
            end
          end
          ST_REQ: begin
            if (i_mem_icache_gnt) begin
              r_state   <= ST_WAIT;
              r_mem_req <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (i_mem_icache_rvld) begin
              r_state <= ST_IDLE;
              r_vld   <= 1'b1;
              r_id    <= w_head_id;
              r_data  <= i_mem_icache_rdata;
            end
          end
          ST_DRAIN: begin
            if (i_mem_icache_rvld) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_icache_ifu_vld  = r_vld;
  assign o_icache_ifu_id   = r_id;
  assign o_icache_ifu_data = r_data;
  assign o_icache_mem_req  = r_mem_req;
  assign o_icache_mem_addr = r_mem_addr;

endmodule

// File: tb/tb_icache_fetch_resp.sv
// tb_icache_fetch_resp: directed and randomized checks of the fetch
// responder against a transaction-level queue model.
module tb_icache_fetch_resp;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_vld = 1'b0;
  logic [31:0]  i_pc = '0;
  logic [1:0]   i_id = '0;
  logic         o_stall;
  logic         o_vld;
  logic [1:0]   o_id;
  logic [127:0] o_data;
  logic         o_mem_req;
  logic [31:0]  o_mem_addr;
  logic         i_gnt = 1'b0;
  logic         i_rvld = 1'b0;
  logic [127:0] i_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [27:0] a;
    logic [1:0]  id;
  } ent_t;

  ent_t         mq[$];
  bit           outst;
  bit           due;
  logic [1:0]   due_id;
  logic [127:0] due_data;
  bit           gen;

  always #5 clk = ~clk;

  icache_fetch_resp dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_flush              (i_flush),
    .i_ifu_icache_vld     (i_vld),
    .i_ifu_icache_pc_addr (i_pc),
    .i_ifu_icache_id      (i_id),
    .o_icache_ifu_stall   (o_stall),
    .o_icache_ifu_vld     (o_vld),
    .o_icache_ifu_id      (o_id),
    .o_icache_ifu_data    (o_data),
    .o_icache_mem_req     (o_mem_req),
    .o_icache_mem_addr    (o_mem_addr),
    .i_mem_icache_gnt     (i_gnt),
    .i_mem_icache_rvld    (i_rvld),
    .i_mem_icache_rdata   (i_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line(input logic [31:0] pc);
    return pc & 32'hFFFF_FFF0;
  endfunction

  task automatic push(input logic [31:0] pc, input logic [1:0] id);
    chk("push_nostall", o_stall, 1'b0);
    i_vld = 1'b1;
    i_pc  = pc;
    i_id  = id;
    step();
    i_vld = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [31:0] pc,
                       input logic [1:0] id, input logic [127:0] d);
    for (int k = 0; k < 12 && o_mem_req !== 1'b1; k++) step();
    chk({tag, "_req"}, o_mem_req, 1'b1);
    chk({tag, "_addr"}, o_mem_addr, line(pc));
    i_gnt = 1'b1;
    step();
    i_gnt = 1'b0;
    i_rvld  = 1'b1;
    i_rdata = d;
    step();
    i_rvld = 1'b0;
    chk({tag, "_vld"}, o_vld, 1'b1);
    chk({tag, "_id"}, o_id, id);
    chk({tag, "_data"}, o_data, d);
  endtask

  task automatic wait_req();
    for (int k = 0; k < 12 && o_mem_req !== 1'b1; k++) step();
    chk("wait_req", o_mem_req, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_stall", o_stall, 1'b0);
    chk("rst_vld", o_vld, 1'b0);
    chk("rst_req", o_mem_req, 1'b0);
    chk("rst_id", o_id, 2'd0);
    chk("rst_data", o_data, 128'd0);
    chk("rst_addr", o_mem_addr, 32'd0);

    // Single fetch, minimum latency.
    i_vld = 1'b1;
    i_pc  = 32'hFFFF_FFF0;
    i_id  = 2'd0;
    step();
    i_vld = 1'b0;
    chk("t1_n1_req", o_mem_req, 1'b0);
    step();
    chk("t1_n2_req", o_mem_req, 1'b1);
    chk("t1_n2_addr", o_mem_addr, 32'hFFFF_FFF0);
    i_gnt = 1'b1;
    step();
    i_gnt = 1'b0;
    chk("t1_n3_req", o_mem_req, 1'b0);
    i_rvld  = 1'b1;
    i_rdata = {16{8'hA5}};
    step();
    i_rvld = 1'b0;
    chk("t1_n4_vld", o_vld, 1'b1);
    chk("t1_n4_id", o_id, 2'd0);
    chk("t1_n4_data", o_data, {16{8'hA5}});
    step();
    chk("t1_n5_vld", o_vld, 1'b0);

    // Fill with grant withheld.
    push(32'h0000_1000, 2'd0);
    push(32'h0000_2014, 2'd1);
    push(32'h0000_3020, 2'd2);
    push(32'h0000_403C, 2'd3);
    chk("t2_full_stall", o_stall, 1'b1);
    i_vld = 1'b1;
    i_pc  = 32'h0000_5000;
    i_id  = 2'd0;
    step();
    chk("t2_still_stall", o_stall, 1'b1);
    step();
    i_vld = 1'b0;
    serve("t2_r0", 32'h0000_1000, 2'd0, 128'h11);
    chk("t2_unstall", o_stall, 1'b0);
    serve("t2_r1", 32'h0000_2014, 2'd1, 128'h22);
    serve("t2_r2", 32'h0000_3020, 2'd2, 128'h33);
    serve("t2_r3", 32'h0000_403C, 2'd3, 128'h44);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_no_fifth", o_mem_req, 1'b0);
    end

    // Pointer wrap with interleaved pops.
    push(32'h0000_6000, 2'd0);
    push(32'h0000_6010, 2'd1);
    push(32'h0000_6020, 2'd2);
    serve("t3_r0", 32'h0000_6000, 2'd0, 128'hA0);
    serve("t3_r1", 32'h0000_6010, 2'd1, 128'hA1);
    push(32'h0000_7030, 2'd3);
    push(32'h0000_7040, 2'd0);
    push(32'h0000_7050, 2'd1);
    serve("t3_r2", 32'h0000_6020, 2'd2, 128'hA2);
    serve("t3_r3", 32'h0000_7030, 2'd3, 128'hA3);
    serve("t3_r4", 32'h0000_7040, 2'd0, 128'hA4);
    serve("t3_r5", 32'h0000_7050, 2'd1, 128'hA5);

    // Flush in WAIT, late data drained.
    push(32'h0000_0200, 2'd1);
    wait_req();
    i_gnt = 1'b1;
    step();
    i_gnt   = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_vld = 1'b1;
    i_pc  = 32'h0000_0500;
    i_id  = 2'd0;
    chk("t4_d1_stall", o_stall, 1'b1);
    chk("t4_d1_req", o_mem_req, 1'b0);
    step();
    chk("t4_d2_stall", o_stall, 1'b1);
    chk("t4_d2_vld", o_vld, 1'b0);
    step();
    chk("t4_d3_stall", o_stall, 1'b1);
    i_rvld  = 1'b1;
    i_rdata = 128'hDEAD;
    step();
    i_rvld = 1'b0;
    i_vld  = 1'b0;
    chk("t4_drop_vld", o_vld, 1'b0);
    chk("t4_idle_stall", o_stall, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_no_req", o_mem_req, 1'b0);
    end
    push(32'h0000_0100, 2'd2);
    serve("t4_new", 32'h0000_0100, 2'd2, 128'hBEEF);

    // Flush in REQ without grant; same-cycle request dropped.
    push(32'h0000_0300, 2'd3);
    wait_req();
    i_flush = 1'b1;
    i_vld   = 1'b1;
    i_pc    = 32'h0000_0700;
    i_id    = 2'd1;
    step();
    i_flush = 1'b0;
    i_vld   = 1'b0;
    chk("t5_req_drop", o_mem_req, 1'b0);
    chk("t5_not_drain", o_stall, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_empty", o_mem_req, 1'b0);
    end
    push(32'h0000_0340, 2'd3);
    serve("t5_new", 32'h0000_0340, 2'd3, 128'hC0DE);

    // Reset while waiting for data.
    push(32'h0000_0400, 2'd1);
    wait_req();
    i_gnt = 1'b1;
    step();
    i_gnt = 1'b0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_vld", o_vld, 1'b0);
    chk("t6_id", o_id, 2'd0);
    chk("t6_data", o_data, 128'd0);
    chk("t6_req", o_mem_req, 1'b0);
    chk("t6_addr", o_mem_addr, 32'd0);
    chk("t6_stall", o_stall, 1'b0);
    i_rvld  = 1'b1;
    i_rdata = 128'hBAD;
    step();
    i_rvld = 1'b0;
    chk("t6_stray_vld", o_vld, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_req", o_mem_req, 1'b0);
    end

    // Randomized traffic against the queue model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    outst = 1'b0;
    due   = 1'b0;
    gen   = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (c == 600) gen = 1'b0;
      chk("rnd_vld", o_vld, due);
      if (due) begin
        chk("rnd_id", o_id, due_id);
        chk("rnd_data", o_data, due_data);
      end
      due = 1'b0;
      chk("rnd_stall", o_stall, mq.size() == 4);
      if (outst) chk("rnd_req_wait", o_mem_req, 1'b0);
      i_gnt  = 1'b0;
      i_rvld = 1'b0;
      if (outst && $urandom_range(0, 2) != 0) begin
        i_rvld   = 1'b1;
        i_rdata  = {$urandom, $urandom, $urandom, $urandom};
        due      = 1'b1;
        due_id   = mq[0].id;
        due_data = i_rdata;
        void'(mq.pop_front());
        outst = 1'b0;
      end else if (o_mem_req && !outst) begin
        chk("rnd_req_nonempty", mq.size() != 0, 1'b1);
        chk("rnd_addr", o_mem_addr, {mq[0].a, 4'h0});
        if ($urandom_range(0, 1) != 0) begin
          i_gnt = 1'b1;
          outst = 1'b1;
        end
      end
      i_vld = gen && ($urandom_range(0, 1) != 0);
      i_pc  = $urandom;
      i_id  = 2'($urandom_range(0, 3));
      if (i_vld && !o_stall) mq.push_back({i_pc[31:4], i_id});
      step();
    end
    i_vld  = 1'b0;
    i_gnt  = 1'b0;
    i_rvld = 1'b0;
    chk("rnd_last_vld", o_vld, due);
    chk("rnd_drained", mq.size(), 0);
    chk("rnd_outst", outst, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetch_resp.md
Name: icache_fetch_resp

Overview:
- Instruction-side responder to the IFU fetch request interface.
- Accepts 16-byte-aligned fetch requests tagged with a 2-bit id and queues up to 4 in order.
- Issues one line read at a time to the memory port and returns each 128-bit line to the IFU with the original id.
- Drives the stall back-pressure and discards in-flight work on any pipeline flush.

Parameters:
PC_WIDTH, 32, fetch address width (matches `CORE_PC_WIDTH).
LINE_WIDTH, 128, fetch line data width (16 bytes).
DEPTH, 4, request queue entries (equals the IFU id space).

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
i_flush  input  1  OR of all IFU flush sources (trap, exu mispredict/ls, iq, iq_uc, bpu)
i_ifu_icache_vld  input  1  fetch request valid
i_ifu_icache_pc_addr  input  PC_WIDTH  fetch address
i_ifu_icache_id  input  2  request tag
o_icache_ifu_stall  output  1  back-pressure; request not accepted while high
o_icache_ifu_vld  output  1  response valid, single-cycle pulse
o_icache_ifu_id  output  2  tag of returned line
o_icache_ifu_data  output  LINE_WIDTH  fetched line
o_icache_mem_req  output  1  memory read request
o_icache_mem_addr  output  PC_WIDTH  line address, low 4 bits zero
i_mem_icache_gnt  input  1  request accepted by memory
i_mem_icache_rvld  input  1  read data valid
i_mem_icache_rdata  input  LINE_WIDTH  read data

Behaviour:
- Reset (rst=1 at a clk edge):
  - Queue is emptied, count=0, FSM=IDLE.
  - o_icache_ifu_vld=0, o_icache_mem_req=0, o_icache_ifu_stall=0.
  - id/data/addr outputs are 0.
  - Reset mid-transaction abandons it; a late rvld after reset while in IDLE is ignored.
- Accept: push {pc_addr[PC_WIDTH-1:4],id} when i_ifu_icache_vld & ~o_icache_ifu_stall & ~i_flush.
- Stall (combinational): o_icache_ifu_stall = (count==DEPTH) | (state==DRAIN).
- Queue: circular, 2-bit rd/wr pointers wrap 3->0, 3-bit count.
  - Push and pop in the same cycle leave count unchanged.
  - Push while full cannot occur, because stall is asserted.
- FSM states IDLE, REQ, WAIT, DRAIN:
  - IDLE: if count!=0 and no flush, go to REQ next cycle.
  - REQ: o_icache_mem_req=1, o_icache_mem_addr={head addr,4'b0}. On gnt, go to WAIT.
  - WAIT: on rvld, pop the head, register the response, go to IDLE.
  - DRAIN: wait for rvld, discard the data, go to IDLE. No response is issued.
- Response: registered. Cycle M has rvld in WAIT; cycle M+1 has o_icache_ifu_vld=1, id=head id, data=rdata. vld is 0 in all other cycles.
- Minimum latency (gnt and rvld both immediate):
  - Accept at cycle N, REQ at N+2, WAIT at N+3, rvld at N+3, response at N+4.
  - Back-to-back requests are therefore serviced one per 3 cycles.
- Flush (i_flush=1 at an edge), highest priority:
  - Queue cleared, count=0. The same-cycle request is not accepted.
  - Pending registered response is suppressed: o_icache_ifu_vld=0 next cycle.
  - REQ without gnt that cycle: go to IDLE (the request may be withdrawn before grant).
  - REQ with gnt: go to DRAIN.
  - WAIT without rvld: go to DRAIN.
  - WAIT with rvld: go to IDLE, data discarded.
  - DRAIN: remain in DRAIN.
- Flush while in DRAIN keeps DRAIN. Exactly one outstanding memory read is ever drained.
- The memory port guarantees at most one rvld per gnt.

Decomposition:
- Shared package: FSM state encoding (2 bits) and FETCH_LINE_BYTES=16 / offset-bits=4 constant, in the ifu/icache defines header.
- One natural sub-module: icache_fetch_reqq, a DEPTH-entry circular queue with push/pop/flush, count, full/empty, and head {addr,id}.
- The FSM and response register live in the top module.

Test Plan:
- Single fetch: pc=0xFFFFFFF0 id=0, gnt and rvld immediate, rdata=0xA5..A5 -> mem_addr=0xFFFFFFF0 at N+2; o_vld at N+4 with id=0 and data 0xA5..A5.
- Fill: 4 back-to-back requests (ids 0-3), gnt withheld -> stall=1 from cycle after the 4th accept; 5th request ignored; responses return in order with ids 0,1,2,3.
- Wrap: 6 requests (ids 0,1,2,3,0,1) with pops interleaved -> pointers wrap; addresses/ids returned match push order exactly.
- Flush in WAIT: flush one cycle after gnt, rvld 3 cycles later -> stall=1 during DRAIN; no o_vld; then new request 0x100 id=2 returns with id=2.
- Flush in REQ without gnt: req drops next cycle; state IDLE; count=0; no memory read is drained.
- Reset mid-WAIT: rst=1 for 1 cycle -> all outputs 0; a subsequent stray rvld produces no o_vld.
